// File: rtl/mel_log_pkg.sv
// Shared constants, log2 mantissa table and pipeline stage record for mel_log_comp.
package mel_log_pkg;

  localparam int unsigned FRAC_DEF     = 8;
  localparam int unsigned LUT_BITS_DEF = 6;
  localparam int unsigned DB_MUL       = 49321;  // 10*log10(2) in Q2.14
  localparam int unsigned DB_SHIFT     = 14;

  // round(log2(1 + i/64) * 256)
  localparam logic [7:0] LOG_LUT [0:63] = '{
    8'd0,   8'd6,   8'd11,  8'd17,  8'd22,  8'd28,  8'd33,  8'd38,
    8'd44,  8'd49,  8'd54,  8'd59,  8'd63,  8'd68,  8'd73,  8'd78,
    8'd82,  8'd87,  8'd92,  8'd96,  8'd100, 8'd105, 8'd109, 8'd113,
    8'd118, 8'd122, 8'd126, 8'd130, 8'd134, 8'd138, 8'd142, 8'd146,
    8'd150, 8'd154, 8'd157, 8'd161, 8'd165, 8'd169, 8'd172, 8'd176,
    8'd179, 8'd183, 8'd186, 8'd190, 8'd193, 8'd197, 8'd200, 8'd203,
    8'd207, 8'd210, 8'd213, 8'd216, 8'd220, 8'd223, 8'd226, 8'd229,
    8'd232, 8'd235, 8'd238, 8'd241, 8'd244, 8'd247, 8'd250, 8'd253
  };

  typedef struct packed {
    logic                    valid;
    logic                    zero;
    logic [7:0]              p;
    logic [LUT_BITS_DEF-1:0] m;
    logic [7:0]              idx;
  } mel_stage_t;

endpackage

// File: rtl/mel_log_fifo.sv
// First-word-fall-through FIFO; an extra pointer MSB separates full from empty.
module mel_log_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          wr_en, rd_en;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    wr_en   = push_i && (!full_o || pop_i);
    rd_en   = pop_i && !empty_o;
    rdata_o = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mel_log_comp.sv
// Mel energy -> fixed-point log2 pipeline feeding a FWFT output FIFO.
// Define MEL_LOG_DB_EN to add a stage that rescales the result to a dB-like scale.
module mel_log_comp
  import mel_log_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned N_MEL      = 40,
  parameter int unsigned FRAC       = FRAC_DEF,
  parameter int unsigned LUT_BITS   = LUT_BITS_DEF,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mel_spec_vld,
  input  logic [WIDTH-1:0] mel_spec,
  input  logic [7:0]       mel_cnt,
  output logic             log_vld,
  input  logic             log_rdy,
  output logic [OUT_W-1:0] log_mel,
  output logic [7:0]       log_idx,
  output logic             log_last,
  output logic             fifo_ovf,
  output logic             seq_err
);

  localparam int unsigned DW = OUT_W + 8;

  logic             v1_q, z1_q;
  logic [7:0]       p1_q, idx1_q, exp_idx_q;
  logic [WIDTH-1:0] x1_q;
  mel_stage_t       s2_q, s2_d;
  logic             v3_q;
  logic [7:0]       idx3_q;
  logic [OUT_W-1:0] r3_q, r3_d;
  logic             seq_err_q, fifo_ovf_q;

  logic [7:0]       lead_p;
  logic [WIDTH-1:0] norm_d;
  logic             push_v, pop, full, empty;
  logic [7:0]       push_idx;
  logic [OUT_W-1:0] push_val;
  logic [DW-1:0]    head;

  always_comb begin
    lead_p = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (mel_spec[i]) lead_p = 8'(i);
  end

  // Left-align the leading one at the MSB; the mantissa is the bits just below it.
  always_comb begin
    norm_d     = x1_q << (8'(WIDTH - 1) - p1_q);
    s2_d.valid = v1_q;
    s2_d.zero  = z1_q;
    s2_d.p     = p1_q;
    s2_d.m     = LUT_BITS'(norm_d >> (WIDTH - 1 - LUT_BITS));
    s2_d.idx   = idx1_q;
    r3_d       = s2_q.zero ? '0
               : (OUT_W'(s2_q.p) << FRAC) + OUT_W'(LOG_LUT[s2_q.m]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      z1_q      <= 1'b0;
      p1_q      <= '0;
      idx1_q    <= '0;
      x1_q      <= '0;
      exp_idx_q <= '0;
      seq_err_q <= 1'b0;
      s2_q      <= '0;
      v3_q      <= 1'b0;
      idx3_q    <= '0;
      r3_q      <= '0;
    end else begin
      v1_q <= mel_spec_vld;
      if (mel_spec_vld) begin
        x1_q   <= mel_spec;
        idx1_q <= mel_cnt;
        p1_q   <= lead_p;
        z1_q   <= (mel_spec == '0);
        if (mel_cnt != exp_idx_q) seq_err_q <= 1'b1;
        // Follow upstream's index so one bad band flags only once.
        exp_idx_q <= (mel_cnt == 8'(N_MEL - 1)) ? '0 : mel_cnt + 8'd1;
      end
      s2_q   <= s2_d;
      v3_q   <= s2_q.valid;
      idx3_q <= s2_q.idx;
      r3_q   <= r3_d;
    end
  end

`ifdef MEL_LOG_DB_EN
  typedef logic [OUT_W+17:0] prod_t;
  prod_t            db_d;
  logic             v4_q;
  logic [7:0]       idx4_q;
  logic [OUT_W-1:0] r4_q;

  always_comb
    db_d = (prod_t'(r3_q) * prod_t'(DB_MUL) + prod_t'(1 << (DB_SHIFT - 1))) >> DB_SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v4_q   <= 1'b0;
      idx4_q <= '0;
      r4_q   <= '0;
    end else begin
      v4_q   <= v3_q;
      idx4_q <= idx3_q;
      r4_q   <= OUT_W'(db_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && v3_q) assert ((db_d >> OUT_W) == '0);
  end

  always_comb begin
    push_v   = v4_q;
    push_idx = idx4_q;
    push_val = r4_q;
  end
`else
  always_comb begin
    push_v   = v3_q;
    push_idx = idx3_q;
    push_val = r3_q;
  end
`endif

  mel_log_fifo #(
    .DEPTH(FIFO_DEPTH),
    .DW   (DW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_v),
    .wdata_i({push_idx, push_val}),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           fifo_ovf_q <= 1'b0;
    else if (push_v && full && !pop)   fifo_ovf_q <= 1'b1;
  end

  always_comb begin
    log_vld  = !empty;
    pop      = log_vld && log_rdy;
    log_mel  = empty ? '0 : head[OUT_W-1:0];
    log_idx  = empty ? '0 : head[DW-1 -: 8];
    log_last = !empty && (head[DW-1 -: 8] == 8'(N_MEL - 1));
    fifo_ovf = fifo_ovf_q;
    seq_err  = seq_err_q;
  end

endmodule

// File: doc/mel_log_comp.md
Name: mel_log_comp

Overview:
- Downstream neighbour of the mel filter-bank stage; consumes its per-band stream (mel_spec_vld, mel_spec, mel_cnt).
- Converts each mel energy to fixed-point log2, using leading-one detection plus a mantissa LUT, in a 3-stage pipeline.
- Buffers results in a FIFO and presents them on a valid/ready stream with band index and end-of-frame marker to the feature/classifier stage.
- The upstream interface has no backpressure, so overflow and band-sequence errors are flagged, never stalled.

Parameters:
- WIDTH, 16, input mel energy width (unsigned).
- N_MEL, 40, bands per frame.
- FRAC, 8, fractional bits of the log output.
- LUT_BITS, 6, mantissa bits indexing the log LUT (2^LUT_BITS entries).
- OUT_W, 16, output word width.
- FIFO_DEPTH, 64, output FIFO entries; must be a power of 2 and >= N_MEL.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mel_spec_vld  in  1  input band valid; one-cycle pulse per band.
- mel_spec  in  WIDTH  band energy, unsigned.
- mel_cnt  in  8  band index of this sample from upstream.
- log_vld  out  1  output word valid.
- log_rdy  in  1  downstream ready.
- log_mel  out  OUT_W  log value; unsigned Q(OUT_W-FRAC).FRAC.
- log_idx  out  8  band index carried with the word.
- log_last  out  1  high when log_idx == N_MEL-1.
- fifo_ovf  out  1  sticky; a result was dropped because the FIFO was full.
- seq_err  out  1  sticky; mel_cnt differed from the expected band index.

Behaviour:
- Reset (asynchronous, rst=1): all pipeline valids cleared, FIFO emptied, expected-index counter = 0. Outputs: log_vld=0, log_mel=0, log_idx=0, log_last=0, fifo_ovf=0, seq_err=0. A reset mid-frame discards all in-flight data.
- Stage 1 (edge E, when mel_spec_vld=1):
  - Register x = mel_spec and mel_cnt.
  - Compute p = position of the leading one, 0..WIDTH-1; x=0 gives p=0 with a zero flag.
  - Check sequence: if mel_cnt != exp_idx, set seq_err.
  - exp_idx <= (mel_cnt == N_MEL-1) ? 0 : mel_cnt+1. This resynchronises to upstream, so a single error does not cascade.
- Stage 2 (edge E+1): m = top LUT_BITS bits below the leading one, zero-padded on the right when p < LUT_BITS.
- Stage 3 (edge E+2):
  - r = (p << FRAC) + LUT[m], where LUT[i] = round(log2(1+i/2^LUT_BITS) * 2^FRAC).
  - Zero input forces r = 0, the same value as x=1.
  - r is zero-extended to OUT_W; log2 max is < WIDTH*2^FRAC (4096 at defaults), which fits.
- FIFO write (edge E+3):
  - Push accepted if !full, or if full and a pop occurs on the same edge.
  - Otherwise the word is dropped and fifo_ovf is set; it is sticky until reset.
- FIFO output is first-word-fall-through: log_vld = !empty. The head word drives log_mel, log_idx and log_last.
- Pop occurs when log_vld && log_rdy.
- Latency: sample accepted at edge E appears with log_vld=1 after edge E+3 if the FIFO was empty.
- Throughput: one band per cycle sustained.
- Output words stay stable while log_vld=1 and log_rdy=0.
- Empty FIFO with log_rdy=1: no pop, no pointer change.
- Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.

Optional Feature:
- Macro MEL_LOG_DB_EN.
- Defined:
  - One extra pipeline stage converts to a dB-like scale: log_mel = (r*49321 + 8192) >> 14, i.e. r * 10*log10(2) (3.0103 in Q2.14), rounded.
  - Latency becomes E+4; the result must fit OUT_W, so the widest product is checked by assertion.
- Undefined: no extra stage; log_mel = r.

Decomposition:
- Package mel_log_pkg holds:
  - FRAC and LUT_BITS defaults.
  - The LUT constant array, or a function generating it.
  - The DB constant 49321 and its shift of 14.
  - The pipeline-stage struct/typedef {valid, zero, p, m, idx}.
- Sub-module mel_log_fifo: synchronous FWFT FIFO with parameters DEPTH and data width OUT_W+8, and push/pop/full/empty ports.

Test Plan:
- Single samples, log_rdy=1: mel_spec=1 -> log_mel=0; 0x8000 -> 3840; 3 -> 406 (256+150); 0 -> 0. Each appears 3 edges after the input with the correct log_idx.
- Full frame, mel_cnt 0..39 back-to-back, log_rdy=1: 40 words out in order; log_last only on idx 39; seq_err=0.
- Backpressure: log_rdy=0 for a 40-band frame -> 40 words held, no ovf. Then raise log_rdy -> all 40 drain unchanged, one per cycle.
- Overflow: FIFO_DEPTH=64, log_rdy=0, send 70 bands -> first 64 kept, fifo_ovf=1 from the 65th write edge. A simultaneous pop on a full FIFO accepts the push without ovf.
- Sequence error: mel_cnt 0,1,2,5,6 -> seq_err=1 at the stage-1 edge of sample 5; the following 6 is accepted as in sequence, and seq_err stays sticky.
- Reset mid-frame with 10 words buffered: rst pulse -> log_vld=0 immediately, flags cleared; the next frame starting at mel_cnt=0 gives no seq_err. With MEL_LOG_DB_EN defined, 0x8000 -> 11560 at latency E+4.
